// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver (5-8 data bits, none/even/odd parity, 1 or 2 stop bits).
// Latency: valid rises 1 clk after the resolve of the last stop bit, plus SYNC_STAGES clks from the rx pin.
// Backpressure: one-word holding register; a good frame arriving while valid && !ready is dropped and flagged by overflow.
//
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   divisor         - clk cycles per bit (>= 4), latched at start detect
//   data_bits       - data bits per frame (5-8, other values mean 8), latched at start detect
//   parity_mode     - 00 none, 01 even, 10 odd, 11 none; latched at start detect
//   two_stop        - check a second stop bit; latched at start detect
//   rx              - asynchronous serial line, idle high
//   data/valid/ready- received word (right-aligned) with valid/ready handshake
//   overflow, frame_error, parity_error - one-cycle event pulses
//   brk             - one-cycle pulse on an all-zero frame (only with UART_RX_BREAK_EN)
//
// Build option: define UART_RX_BREAK_EN to add the brk output.
module uart_rx_cfg #(
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic [3:0]           data_bits,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 rx,
    output logic [7:0]           data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overflow,
`ifdef UART_RX_BREAK_EN
    output logic                 brk,
`endif
    output logic                 frame_error,
    output logic                 parity_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_ERROR
    } state_t;

    state_t state_q, state_d;

    // Synchronizer; flops reset to the idle level so reset never looks like a start bit.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev_q;

    // Per-frame configuration captured at start detect
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [3:0]           nbits_q, nbits_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 two_stop_q, two_stop_d;

    // Bit timer and sampling
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] mid, mid_m1, mid_p1, div_m1;
    logic [1:0]           smp_q, smp_d;
    logic                 maj, resolve, cnt_last, fall;

    // Frame datapath
    logic [3:0] bit_idx_q, bit_idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic       par_acc_q, par_acc_d;
    logic       par_err_q, par_err_d;
    logic       frame_done;

    // Outputs
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;
    logic       ferr_q, ferr_d;
    logic       perr_q, perr_d;
`ifdef UART_RX_BREAK_EN
    logic       brk_q, brk_d;
    logic       zero_q, zero_d;    // every data/parity/stop sample so far was 0
`endif

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign fall     = rxs_prev_q & ~rxs;
    assign mid      = div_q >> 1;
    assign mid_m1   = mid - DIV_WIDTH'(1);
    assign mid_p1   = mid + DIV_WIDTH'(1);
    assign div_m1   = div_q - DIV_WIDTH'(1);
    assign cnt_last = (cnt_q == div_m1);
    assign resolve  = (cnt_q == mid_p1);
    // Third vote is the live sample taken on the resolve cycle itself.
    assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

    // A good stop bit that ends the frame
    assign frame_done = resolve && maj &&
                        (((state_q == S_STOP1) && !two_stop_q) || (state_q == S_STOP2));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (fall) state_d = S_START;
            S_START:  if (resolve) state_d = maj ? S_IDLE : S_DATA;
            S_DATA:   if (resolve && (bit_idx_q == nbits_q - 4'd1))
                          state_d = par_en_q ? S_PARITY : S_STOP1;
            S_PARITY: if (resolve) state_d = S_STOP1;
            S_STOP1:  if (resolve) state_d = !maj ? S_ERROR : (two_stop_q ? S_STOP2 : S_IDLE);
            S_STOP2:  if (resolve) state_d = !maj ? S_ERROR : S_IDLE;
            S_ERROR:  if (rxs && cnt_last) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and output next-state logic
    always_comb begin
        div_d      = div_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        cnt_d      = cnt_q;
        smp_d      = smp_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        par_acc_d  = par_acc_q;
        par_err_d  = par_err_q;
        data_d     = data_q;
        valid_d    = valid_q & ~ready;
        ovf_d      = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
`ifdef UART_RX_BREAK_EN
        brk_d      = 1'b0;
        zero_d     = zero_q;
`endif
        if (state_q == S_IDLE) begin
            if (fall) begin
                cnt_d      = '0;
                div_d      = divisor;
                nbits_d    = ((data_bits >= 4'd5) && (data_bits <= 4'd8)) ? data_bits : 4'd8;
                par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_odd_d  = (parity_mode == 2'b10);
                two_stop_d = two_stop;
                bit_idx_d  = '0;
                par_acc_d  = 1'b0;
                par_err_d  = 1'b0;
`ifdef UART_RX_BREAK_EN
                zero_d     = 1'b1;
`endif
            end
        end else if (state_q == S_ERROR) begin
            // Counts consecutive high cycles; any low restarts the wait.
            cnt_d = rxs ? cnt_q + DIV_WIDTH'(1) : '0;
        end else begin
            // The timer free-runs across bit boundaries, so the next bit resolves
            // exactly one period after the current one.
            cnt_d = cnt_last ? '0 : cnt_q + DIV_WIDTH'(1);
            if (cnt_q == mid_m1) smp_d[0] = rxs;
            if (cnt_q == mid)    smp_d[1] = rxs;
            if (resolve) begin
                case (state_q)
                    S_DATA: begin
                        shreg_d   = {maj, shreg_q[7:1]};
                        par_acc_d = par_acc_q ^ maj;
                        bit_idx_d = bit_idx_q + 4'd1;
`ifdef UART_RX_BREAK_EN
                        zero_d    = zero_q & ~maj;
`endif
                    end
                    S_PARITY: begin
                        par_err_d = maj ^ par_acc_q ^ par_odd_q;
`ifdef UART_RX_BREAK_EN
                        zero_d    = zero_q & ~maj;
`endif
                    end
                    S_STOP1, S_STOP2: begin
                        if (!maj) begin
`ifdef UART_RX_BREAK_EN
                            if (zero_q) brk_d  = 1'b1;
                            else        ferr_d = 1'b1;
`else
                            ferr_d = 1'b1;
`endif
                        end else if (frame_done) begin
                            if (par_err_q) begin
                                perr_d = 1'b1;
                            end else if (valid_q && !ready) begin
                                ovf_d = 1'b1;
                            end else begin
                                // Bits entered at the MSB; shift down to right-align.
                                data_d  = shreg_q >> (4'd8 - nbits_q);
                                valid_d = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
            div_q      <= '0;
            nbits_q    <= 4'd8;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            cnt_q      <= '0;
            smp_q      <= 2'b11;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            par_acc_q  <= 1'b0;
            par_err_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
`ifdef UART_RX_BREAK_EN
            brk_q      <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_prev_q <= rxs;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            cnt_q      <= cnt_d;
            smp_q      <= smp_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            par_acc_q  <= par_acc_d;
            par_err_q  <= par_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
`ifdef UART_RX_BREAK_EN
            brk_q      <= brk_d;
            zero_q     <= zero_d;
`endif
        end
    end

    assign data         = data_q;
    assign valid        = valid_q;
    assign overflow     = ovf_q;
    assign frame_error  = ferr_q;
    assign parity_error = perr_q;
`ifdef UART_RX_BREAK_EN
    assign brk          = brk_q;
`endif

endmodule
